// File: rtl/display_mux_driver.sv
// Four-digit multiplexed 7-segment driver: blanks the outputs after each digit switch and loads new digits only at a frame boundary.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module display_mux_driver #(
  parameter int unsigned BLANK_CYCLES = 1
) (
  input  logic        clk_100,
  input  logic        rst,
  input  logic [1:0]  sel,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic        load_ack,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  // state   | meaning
  // IDLE    | no request outstanding
  // PEND    | load seen, waiting for the frame boundary
  // ACK     | transfer just happened, load_ack high for this cycle
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic [3:0] BLANK_LD = 4'(BLANK_CYCLES);

  state_t      state_q, state_d;
  logic [1:0]  sel_r;
  logic [3:0]  blank_cnt;
  logic [15:0] shadow;
  logic [3:0]  shadow_dp;
  logic        frame_edge;
  logic        xfer;
  logic        lz_blank;
  logic [3:0]  cur_digit;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    s = 7'b0111111;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  assign frame_edge = (sel_r != 2'd0) && (sel == 2'd0);
  assign load_ack   = (state_q == ST_ACK);
  assign cur_digit  = shadow[{sel_r, 2'b00} +: 4];

  always_comb begin
    state_d = state_q;
    xfer    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_edge && load) begin
          xfer    = 1'b1;
          state_d = ST_ACK;
        end else if (load) begin
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (frame_edge) begin
          xfer    = 1'b1;
          state_d = ST_ACK;
        end
      end
      // load is ignored while acking; sel_r is 0 here so no boundary can follow
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    lz_blank = 1'b0;
    case (sel_r)
      2'd3:    lz_blank = (shadow[15:12] == 4'd0);
      2'd2:    lz_blank = (shadow[15:8] == 8'd0);
      2'd1:    lz_blank = (shadow[15:4] == 12'd0);
      default: lz_blank = 1'b0;
    endcase
  end
`else
  assign lz_blank = 1'b0;
`endif

  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      sel_r     <= 2'd0;
      blank_cnt <= 4'd0;
      shadow    <= 16'h0000;
      shadow_dp <= 4'h0;
      an        <= 4'b1111;
      seg       <= 7'b1111111;
      dp        <= 1'b1;
    end else begin
      sel_r <= sel;
      if (sel != sel_r) begin
        blank_cnt <= BLANK_LD;
      end else if (blank_cnt != 4'd0) begin
        blank_cnt <= blank_cnt - 4'd1;
      end
      if (xfer) begin
        shadow    <= bcd_in;
        shadow_dp <= dp_in;
      end
      // outputs come from the pre-edge state so a switch shows the old digit for one more cycle
      if (blank_cnt != 4'd0) begin
        an  <= 4'b1111;
        seg <= 7'b1111111;
        dp  <= 1'b1;
      end else begin
        an  <= ~(4'b0001 << sel_r);
        seg <= lz_blank ? 7'b1111111 : decode(cur_digit);
        dp  <= ~shadow_dp[sel_r];
      end
    end
  end

endmodule

// File: tb/tb_display_mux_driver.sv
// Self-checking bench for display_mux_driver: table of per-digit vectors plus hand-written handshake/blanking sequences.
module tb_display_mux_driver;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk_100 = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        load_ack;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  display_mux_driver #(.BLANK_CYCLES(1)) dut (
    .clk_100 (clk_100),
    .rst     (rst),
    .sel     (sel),
    .bcd_in  (bcd_in),
    .dp_in   (dp_in),
    .load    (load),
    .load_ack(load_ack),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  always #5 clk_100 = ~clk_100;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ack;
  } exp_t;

  typedef struct {
    logic [15:0] shadow;
    logic [3:0]  dpv;
    logic [1:0]  sel;
    logic [6:0]  seg;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[18];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic tick();
    @(posedge clk_100);
    #1;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act[12:0], expv[12:0]);
    end
  endtask

  task automatic push_exp(input logic [3:0] a, input logic [6:0] s, input logic d, input logic k);
    exp_t e;
    e.an = a; e.seg = s; e.dp = d; e.ack = k;
    sb.push_back(e);
  endtask

  task automatic check_out(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      cmp(name, {19'd0, an, seg, dp, load_ack}, {19'd0, e.an, e.seg, e.dp, e.ack});
    end
  endtask

  task automatic do_load(input logic [15:0] b, input logic [3:0] d);
    bit got;
    got    = 1'b0;
    bcd_in = b;
    dp_in  = d;
    load   = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      sel = 2'((i / 2 + 1) % 4);
      tick();
      if (load_ack) got = 1'b1;
    end
    load = 1'b0;
    cmp("load_ack_seen", 32'(got), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] cur_sh;
    logic [3:0]  cur_dp;
    int          acks;

    vecs[0]  = '{16'h1234, 4'b0100, 2'd0, 7'b0011001};
    vecs[1]  = '{16'h1234, 4'b0100, 2'd1, 7'b0110000};
    vecs[2]  = '{16'h1234, 4'b0100, 2'd2, 7'b0100100};
    vecs[3]  = '{16'h1234, 4'b0100, 2'd3, 7'b1111001};
    vecs[4]  = '{16'h0B5E, 4'b1000, 2'd0, 7'b0111111};
    vecs[5]  = '{16'h0B5E, 4'b1000, 2'd1, 7'b0010010};
    vecs[6]  = '{16'h0B5E, 4'b1000, 2'd2, 7'b0111111};
    vecs[7]  = '{16'h0B5E, 4'b1000, 2'd3, LZ ? 7'b1111111 : 7'b1000000};
    vecs[8]  = '{16'h0042, 4'b0000, 2'd3, LZ ? 7'b1111111 : 7'b1000000};
    vecs[9]  = '{16'h0042, 4'b0000, 2'd2, LZ ? 7'b1111111 : 7'b1000000};
    vecs[10] = '{16'h0042, 4'b0000, 2'd1, 7'b0011001};
    vecs[11] = '{16'h0042, 4'b0000, 2'd0, 7'b0100100};
    vecs[12] = '{16'h0000, 4'b0001, 2'd0, 7'b1000000};
    vecs[13] = '{16'h0000, 4'b0001, 2'd1, LZ ? 7'b1111111 : 7'b1000000};
    vecs[14] = '{16'h9876, 4'b0000, 2'd0, 7'b0000010};
    vecs[15] = '{16'h9876, 4'b0000, 2'd1, 7'b1111000};
    vecs[16] = '{16'h9876, 4'b0000, 2'd2, 7'b0000000};
    vecs[17] = '{16'h9876, 4'b0000, 2'd3, 7'b0010000};

    rst = 1'b1; sel = 2'd0; bcd_in = 16'h0; dp_in = 4'h0; load = 1'b0;
    tick(); tick();
    push_exp(4'b1111, 7'b1111111, 1'b1, 1'b0);
    check_out("reset_hold");

    rst = 1'b0;
    push_exp(4'b1110, 7'b1000000, 1'b1, 1'b0);
    tick();
    check_out("first_after_reset");

    cur_sh = 16'hFFFF;
    cur_dp = 4'hF;
    foreach (vecs[k]) begin
      if (vecs[k].shadow != cur_sh || vecs[k].dpv != cur_dp) begin
        do_load(vecs[k].shadow, vecs[k].dpv);
        cur_sh = vecs[k].shadow;
        cur_dp = vecs[k].dpv;
      end
      sel = vecs[k].sel;
      push_exp(~(4'b0001 << vecs[k].sel), vecs[k].seg, ~vecs[k].dpv[vecs[k].sel], 1'b0);
      tick(); tick(); tick();
      check_out($sformatf("vec%0d", k));
    end

    // one blank cycle on 0->1, then digit 1
    do_load(16'h1234, 4'b0000);
    sel = 2'd0;
    tick(); tick(); tick();
    sel = 2'd1;
    tick();
    push_exp(4'b1111, 7'b1111111, 1'b1, 1'b0);
    tick();
    check_out("switch_blank");
    push_exp(4'b1101, 7'b0110000, 1'b1, 1'b0);
    tick();
    check_out("switch_digit1");

    // back-to-back changes restart the blank
    sel = 2'd2;
    tick();
    sel = 2'd3;
    push_exp(4'b1111, 7'b1111111, 1'b1, 1'b0);
    tick();
    check_out("b2b_blank1");
    push_exp(4'b1111, 7'b1111111, 1'b1, 1'b0);
    tick();
    check_out("b2b_blank2");
    push_exp(4'b0111, 7'b1111001, 1'b1, 1'b0);
    tick();
    check_out("b2b_digit3");

    // load held across sel=2,3 is only acked at the 3->0 wrap
    sel = 2'd2;
    tick(); tick(); tick();
    bcd_in = 16'h0597; dp_in = 4'b0001; load = 1'b1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (load_ack) acks++; end
    sel = 2'd3;
    for (int i = 0; i < 3; i++) begin tick(); if (load_ack) acks++; end
    cmp("no_ack_before_wrap", 32'(acks), 32'd0);
    sel = 2'd0;
    tick();
    cmp("ack_at_wrap", 32'(load_ack), 32'd1);
    load = 1'b0;
    push_exp(4'b1111, 7'b1111111, 1'b1, 1'b0);
    tick();
    check_out("ack_one_cycle_blank");
    push_exp(4'b1110, 7'b1111000, 1'b0, 1'b0);
    tick();
    check_out("new_digit0_7");

    // reset mid-request aborts it
    sel = 2'd2;
    tick(); tick();
    bcd_in = 16'hFFFF; dp_in = 4'hF; load = 1'b1;
    tick(); tick();
    rst = 1'b1;
    #1;
    push_exp(4'b1111, 7'b1111111, 1'b1, 1'b0);
    check_out("async_reset_outputs");
    load = 1'b0;
    tick();
    rst = 1'b0;
    acks = 0;
    sel = 2'd3;
    for (int i = 0; i < 3; i++) begin tick(); if (load_ack) acks++; end
    sel = 2'd0;
    for (int i = 0; i < 2; i++) begin tick(); if (load_ack) acks++; end
    cmp("no_ack_after_reset", 32'(acks), 32'd0);
    push_exp(4'b1110, 7'b1000000, 1'b1, 1'b0);
    tick();
    check_out("shadow_cleared_by_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
